wide_aggregator: RTL and testbench

- Runtime-configurable successor to the width-converting aggregator between the CDC SyncFIFO read side and downstream wide consumers.
- Dequeues DATA_WIDTH words from a sender FIFO and packs 1..MAX_FETCH_WIDTH of them into one wide word.
- Adds a registered output stage, per-transfer valid-word count, explicit partial flush, and safe mid-group fetch-width changes.

---
 rtl/agg_pkg.sv | 26 ++
 rtl/agg_out_stage.sv | 57 +++++
 rtl/wide_aggregator.sv | 133 +++++++++++++
 tb/tb_wide_aggregator.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/agg_pkg.sv
// Shared types and helpers for the wide aggregator: FSM states, count-width
// derivation, fetch-width clamping and lane slicing.
package agg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PACK,
    ST_CLOSE_WAIT
  } agg_state_e;

  function automatic int cnt_width(input int max_fw);
    return $clog2(max_fw + 1);
  endfunction

  // Requested widths outside 1..max_fw saturate rather than wrap.
  function automatic int clamp_fw(input int req, input int max_fw);
    if (req < 1) return 1;
    if (req > max_fw) return max_fw;
    return req;
  endfunction

  function automatic int lane_lsb(input int lane, input int data_w);
    return lane * data_w;
  endfunction

endpackage

// File: rtl/agg_out_stage.sv
// Output holding register: keeps a packed group and its lane count stable
// until the receiver accepts it.
module agg_out_stage #(
  parameter int GROUP_W = 64,
  parameter int CNT_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [GROUP_W-1:0] load_data,
  input  logic [CNT_W-1:0]   load_count,
  input  logic               receiver_full_n,
  output logic [GROUP_W-1:0] receiver_data,
  output logic [CNT_W-1:0]   receiver_count,
  output logic               receiver_enq,
  output logic               out_valid,
  output logic               out_free
);

  logic [GROUP_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               valid_q, valid_d;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves a
    // value unassigned and no latch is inferred.
    data_d       = data_q;
    count_d      = count_q;
    valid_d      = valid_q;
    receiver_enq = valid_q & receiver_full_n;
    out_free     = ~valid_q | receiver_full_n;
    if (receiver_enq) valid_d = 1'b0;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
      count_d = load_count;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  assign receiver_data  = data_q;
  assign receiver_count = count_q;
  assign out_valid      = valid_q;

endmodule

// File: rtl/wide_aggregator.sv
// Packs 1..MAX_FETCH_WIDTH sender words into one wide receiver word, with a
// runtime fetch width, explicit partial flush and a registered output stage.
module wide_aggregator
  import agg_pkg::*;
#(
  parameter int DATA_WIDTH          = 8,
  parameter int MAX_FETCH_WIDTH     = 8,
  parameter int DEFAULT_FETCH_WIDTH = 2,
  parameter int CNT_W               = cnt_width(MAX_FETCH_WIDTH)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [DATA_WIDTH-1:0]                 sender_data,
  input  logic                                  sender_empty_n,
  output logic                                  sender_deq,
  output logic [MAX_FETCH_WIDTH*DATA_WIDTH-1:0] receiver_data,
  output logic [CNT_W-1:0]                      receiver_count,
  input  logic                                  receiver_full_n,
  output logic                                  receiver_enq,
  input  logic                                  change_fetch_width,
  input  logic [CNT_W-1:0]                      input_fetch_width,
  input  logic                                  flush,
  output logic                                  busy
);

  localparam int GROUP_W = MAX_FETCH_WIDTH * DATA_WIDTH;
  localparam logic [CNT_W-1:0] FW_RST =
    CNT_W'(clamp_fw(DEFAULT_FETCH_WIDTH, MAX_FETCH_WIDTH));

  agg_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, fw_q, fw_d, fw_next_q, fw_next_d, cnt_inc;
  logic pending_cfg_q, pending_cfg_d, pending_flush_q, pending_flush_d;
  logic [MAX_FETCH_WIDTH-1:0][DATA_WIDTH-1:0] pack_q, pack_d;
  logic [GROUP_W-1:0] grp_data;
  logic close_pending, close_req, load, out_free, out_valid;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    fw_d            = fw_q;
    fw_next_d       = fw_next_q;
    pending_cfg_d   = pending_cfg_q;
    pending_flush_d = pending_flush_q;
    pack_d          = pack_q;
    grp_data        = '0;
    load            = 1'b0;

    // Any pending close freezes the pack register until the group moves out.
    close_pending = (state_q == ST_CLOSE_WAIT) | pending_cfg_q | pending_flush_q;
    // Gated by rst_n so the pop request is low for the whole reset interval.
    sender_deq    = rst_n & sender_empty_n & (cnt_q < fw_q) & ~close_pending;

    for (int l = 0; l < MAX_FETCH_WIDTH; l++)
      if (sender_deq && cnt_q == CNT_W'(l)) pack_d[l] = sender_data;
    cnt_inc   = cnt_q + CNT_W'(sender_deq);
    close_req = (cnt_inc != '0) & ((cnt_inc == fw_q) | close_pending);

    for (int l = 0; l < MAX_FETCH_WIDTH; l++)
      if (CNT_W'(l) < cnt_inc) grp_data[lane_lsb(l, DATA_WIDTH) +: DATA_WIDTH] = pack_d[l];

    if (close_req) begin
      if (out_free) begin
        load            = 1'b1;
        cnt_d           = '0;
        pending_flush_d = 1'b0;
        state_d         = ST_IDLE;
        if (pending_cfg_q) begin
          fw_d          = fw_next_q;
          pending_cfg_d = 1'b0;
        end
      end else begin
        cnt_d   = cnt_inc;
        state_d = ST_CLOSE_WAIT;
      end
    end else begin
      cnt_d   = cnt_inc;
      state_d = (cnt_inc != '0) ? ST_PACK : ST_IDLE;
      if (pending_cfg_q && cnt_inc == '0) begin
        fw_d          = fw_next_q;
        pending_cfg_d = 1'b0;
      end
    end

    // A flush coinciding with a close is absorbed by that close.
    if (flush && !close_req && cnt_inc != '0) pending_flush_d = 1'b1;
    if (change_fetch_width) begin
      fw_next_d     = CNT_W'(clamp_fw(int'(input_fetch_width), MAX_FETCH_WIDTH));
      pending_cfg_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      fw_q            <= FW_RST;
      fw_next_q       <= FW_RST;
      pending_cfg_q   <= 1'b0;
      pending_flush_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      fw_q            <= fw_d;
      fw_next_q       <= fw_next_d;
      pending_cfg_q   <= pending_cfg_d;
      pending_flush_q <= pending_flush_d;
    end
  end

  // NOTE: the pack lanes are pure datapath and are not reset; cnt_q alone
  // says which lanes are valid, and unused lanes are zeroed on load.
  always_ff @(posedge clk) pack_q <= pack_d;

  agg_out_stage #(
    .GROUP_W (GROUP_W),
    .CNT_W   (CNT_W)
  ) u_out_stage (
    .clk             (clk),
    .rst_n           (rst_n),
    .load            (load),
    .load_data       (grp_data),
    .load_count      (cnt_inc),
    .receiver_full_n (receiver_full_n),
    .receiver_data   (receiver_data),
    .receiver_count  (receiver_count),
    .receiver_enq    (receiver_enq),
    .out_valid       (out_valid),
    .out_free        (out_free)
  );

  assign busy = (cnt_q != '0) | out_valid | pending_cfg_q | pending_flush_q;

endmodule

// File: tb/tb_wide_aggregator.sv
// Directed bench for wide_aggregator: FIFO-style sender model, logged receiver
// transfers compared against hand-computed groups.
module tb_wide_aggregator;

  localparam int DW = 8;
  localparam int CW = 4;
  localparam int GW = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] sender_data;
  logic          sender_empty_n;
  logic          sender_deq;
  logic [GW-1:0] receiver_data;
  logic [CW-1:0] receiver_count;
  logic          receiver_full_n;
  logic          receiver_enq;
  logic          change_fetch_width;
  logic [CW-1:0] input_fetch_width;
  logic          flush;
  logic          busy;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  logic [DW-1:0] sq[$];
  logic          src_en;
  logic          rdy;
  logic [GW-1:0] got_data[$];
  logic [CW-1:0] got_cnt[$];
  int            got_cyc[$];
  int            deq_cyc[$];

  always #5 clk = ~clk;

  wide_aggregator #(
    .DATA_WIDTH          (8),
    .MAX_FETCH_WIDTH     (8),
    .DEFAULT_FETCH_WIDTH (2)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .sender_data        (sender_data),
    .sender_empty_n     (sender_empty_n),
    .sender_deq         (sender_deq),
    .receiver_data      (receiver_data),
    .receiver_count     (receiver_count),
    .receiver_full_n    (receiver_full_n),
    .receiver_enq       (receiver_enq),
    .change_fetch_width (change_fetch_width),
    .input_fetch_width  (input_fetch_width),
    .flush              (flush),
    .busy               (busy)
  );

  // Called just after a falling edge: drive, settle, log handshakes, advance.
  task automatic cycle();
    sender_empty_n  = src_en && (sq.size() > 0);
    sender_data     = (sq.size() > 0) ? sq[0] : '0;
    receiver_full_n = rdy;
    #1;
    if (receiver_enq === 1'b1) begin
      got_data.push_back(receiver_data);
      got_cnt.push_back(receiver_count);
      got_cyc.push_back(cyc);
    end
    if (sender_deq === 1'b1) begin
      if (sq.size() > 0) void'(sq.pop_front());
      deq_cyc.push_back(cyc);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic clear_log();
    got_data.delete();
    got_cnt.delete();
    got_cyc.delete();
    deq_cyc.delete();
  endtask

  task automatic push_range(input int first, input int n);
    for (int i = 0; i < n; i++) sq.push_back(DW'(first + i));
  endtask

  task automatic test_reset();
    rst_n = 1'b0; src_en = 1'b1; rdy = 1'b1; flush = 1'b0;
    change_fetch_width = 1'b0; input_fetch_width = '0;
    sender_empty_n = 1'b1; sender_data = 8'h55; receiver_full_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_vec++; if (sender_deq !== 1'b0) begin n_miss++; $display("FAIL reset_deq: got %b want 0", sender_deq); end
    n_vec++; if (receiver_enq !== 1'b0) begin n_miss++; $display("FAIL reset_enq: got %b want 0", receiver_enq); end
    n_vec++; if (receiver_count !== 4'd0) begin n_miss++; $display("FAIL reset_count: got %0d want 0", receiver_count); end
    n_vec++; if (receiver_data !== 64'h0) begin n_miss++; $display("FAIL reset_data: got %h want 0", receiver_data); end
    n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst_n = 1'b1;
    #1;
    n_vec++; if (sender_deq !== 1'b1) begin n_miss++; $display("FAIL post_reset_deq: got %b want 1", sender_deq); end
    sender_empty_n = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_default_width();
    logic [GW-1:0] exp_d [5];
    exp_d = '{64'h0100, 64'h0302, 64'h0504, 64'h0706, 64'h0908};
    clear_log(); rdy = 1'b1; src_en = 1'b1;
    push_range(0, 10);
    run(20);
    n_vec++; if (got_data.size() !== 5) begin n_miss++; $display("FAIL fw2_ngroups: got %0d want 5", got_data.size()); end
    if (got_data.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        int exp_c;
        exp_c = (deq_cyc.size() > 2 * i + 1) ? deq_cyc[2 * i + 1] + 1 : -1;
        n_vec++; if (got_data[i] !== exp_d[i]) begin n_miss++; $display("FAIL fw2_data[%0d]: got %h want %h", i, got_data[i], exp_d[i]); end
        n_vec++; if (got_cnt[i] !== 4'd2) begin n_miss++; $display("FAIL fw2_count[%0d]: got %0d want 2", i, got_cnt[i]); end
        n_vec++; if (got_cyc[i] !== exp_c) begin n_miss++; $display("FAIL fw2_latency[%0d]: got cycle %0d want %0d", i, got_cyc[i], exp_c); end
      end
    end
    n_vec++; if (deq_cyc.size() !== 10 || deq_cyc[9] - deq_cyc[0] !== 9) begin n_miss++; $display("FAIL fw2_throughput: got %0d pops", deq_cyc.size()); end
    n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL fw2_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_width_change();
    clear_log();
    sq.push_back(8'h04);
    run(3);
    n_vec++; if (busy !== 1'b1 || got_data.size() !== 0) begin n_miss++; $display("FAIL wc_hold: busy %b groups %0d want 1/0", busy, got_data.size()); end
    change_fetch_width = 1'b1; input_fetch_width = 4'd4;
    cycle();
    change_fetch_width = 1'b0;
    push_range(5, 4);
    run(12);
    n_vec++; if (got_data.size() !== 2) begin n_miss++; $display("FAIL wc_ngroups: got %0d want 2", got_data.size()); end
    if (got_data.size() == 2) begin
      n_vec++; if (got_data[0] !== 64'h04 || got_cnt[0] !== 4'd1) begin n_miss++; $display("FAIL wc_partial: got %h/%0d want 04/1", got_data[0], got_cnt[0]); end
      n_vec++; if (got_data[1] !== 64'h08070605 || got_cnt[1] !== 4'd4) begin n_miss++; $display("FAIL wc_new_width: got %h/%0d want 08070605/4", got_data[1], got_cnt[1]); end
    end
  endtask

  task automatic test_flush();
    clear_log();
    push_range(8'h0a, 3);
    run(12);
    n_vec++; if (got_data.size() !== 0 || busy !== 1'b1) begin n_miss++; $display("FAIL fl_hold: groups %0d busy %b want 0/1", got_data.size(), busy); end
    flush = 1'b1; cycle(); flush = 1'b0;
    run(4);
    n_vec++; if (got_data.size() !== 1) begin n_miss++; $display("FAIL fl_ngroups: got %0d want 1", got_data.size()); end
    if (got_data.size() == 1) begin
      n_vec++; if (got_data[0] !== 64'h0c0b0a || got_cnt[0] !== 4'd3) begin n_miss++; $display("FAIL fl_partial: got %h/%0d want 0c0b0a/3", got_data[0], got_cnt[0]); end
    end
    // Flush with nothing packed must not produce a transfer.
    clear_log();
    flush = 1'b1; cycle(); flush = 1'b0;
    run(4);
    n_vec++; if (got_data.size() !== 0 || busy !== 1'b0) begin n_miss++; $display("FAIL fl_empty: groups %0d busy %b want 0/0", got_data.size(), busy); end
    // Flush on the cycle a word is accepted includes that word.
    clear_log();
    sq.push_back(8'h20);
    flush = 1'b1; cycle(); flush = 1'b0;
    run(4);
    n_vec++; if (got_data.size() !== 1 || got_data[0] !== 64'h20 || got_cnt[0] !== 4'd1) begin n_miss++; $display("FAIL fl_same_cycle: groups %0d first %h", got_data.size(), got_data.size() ? got_data[0] : 64'h0); end
    // Flush on a natural close is absorbed; the group goes out full.
    clear_log();
    push_range(8'h30, 3);
    run(5);
    sq.push_back(8'h33);
    flush = 1'b1; cycle(); flush = 1'b0;
    run(5);
    n_vec++; if (got_data.size() !== 1 || got_data[0] !== 64'h33323130 || got_cnt[0] !== 4'd4) begin n_miss++; $display("FAIL fl_natural: groups %0d first %h", got_data.size(), got_data.size() ? got_data[0] : 64'h0); end
    n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL fl_natural_busy: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [GW-1:0] exp_d [4];
    exp_d = '{64'h43424140, 64'h47464544, 64'h4b4a4948, 64'h4f4e4d4c};
    clear_log(); rdy = 1'b0;
    push_range(8'h40, 16);
    run(20);
    n_vec++; if (deq_cyc.size() !== 8) begin n_miss++; $display("FAIL bp_buffered: got %0d pops want 8", deq_cyc.size()); end
    n_vec++; if (sender_deq !== 1'b0 || receiver_enq !== 1'b0) begin n_miss++; $display("FAIL bp_stall: deq %b enq %b want 0/0", sender_deq, receiver_enq); end
    n_vec++; if (receiver_data !== 64'h43424140 || receiver_count !== 4'd4) begin n_miss++; $display("FAIL bp_stable: got %h/%0d want 43424140/4", receiver_data, receiver_count); end
    rdy = 1'b1;
    run(20);
    n_vec++; if (got_data.size() !== 4) begin n_miss++; $display("FAIL bp_ngroups: got %0d want 4", got_data.size()); end
    if (got_data.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        n_vec++; if (got_data[i] !== exp_d[i] || got_cnt[i] !== 4'd4) begin n_miss++; $display("FAIL bp_group[%0d]: got %h/%0d want %h/4", i, got_data[i], got_cnt[i], exp_d[i]); end
      end
      n_vec++; if (got_cyc[1] - got_cyc[0] !== 1) begin n_miss++; $display("FAIL bp_b2b: gap %0d want 1", got_cyc[1] - got_cyc[0]); end
    end
  endtask

  task automatic test_clamp();
    clear_log();
    change_fetch_width = 1'b1; input_fetch_width = 4'd0;
    cycle();
    change_fetch_width = 1'b0;
    push_range(8'h50, 3);
    run(8);
    n_vec++; if (got_data.size() !== 3) begin n_miss++; $display("FAIL cl0_ngroups: got %0d want 3", got_data.size()); end
    if (got_data.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        n_vec++; if (got_data[i] !== GW'(8'h50 + i) || got_cnt[i] !== 4'd1) begin n_miss++; $display("FAIL cl0_group[%0d]: got %h/%0d want %h/1", i, got_data[i], got_cnt[i], 8'h50 + i); end
      end
      n_vec++; if (got_cyc[2] - got_cyc[0] !== 2) begin n_miss++; $display("FAIL cl0_rate: span %0d want 2", got_cyc[2] - got_cyc[0]); end
    end
    clear_log();
    change_fetch_width = 1'b1; input_fetch_width = 4'd15;
    cycle();
    change_fetch_width = 1'b0;
    push_range(8'h60, 8);
    run(15);
    n_vec++; if (got_data.size() !== 1 || got_data[0] !== 64'h6766656463626160 || got_cnt[0] !== 4'd8) begin n_miss++; $display("FAIL cl15_group: groups %0d first %h", got_data.size(), got_data.size() ? got_data[0] : 64'h0); end
  endtask

  task automatic test_reset_mid();
    clear_log(); rdy = 1'b0;
    push_range(8'h70, 12);
    run(10);
    n_vec++; if (receiver_count !== 4'd8 || busy !== 1'b1) begin n_miss++; $display("FAIL rm_setup: count %0d busy %b want 8/1", receiver_count, busy); end
    rst_n = 1'b0; rdy = 1'b1; receiver_full_n = 1'b1;
    #1;
    n_vec++; if (receiver_enq !== 1'b0 || sender_deq !== 1'b0) begin n_miss++; $display("FAIL rm_handshake: enq %b deq %b want 0/0", receiver_enq, sender_deq); end
    n_vec++; if (receiver_count !== 4'd0 || receiver_data !== 64'h0 || busy !== 1'b0) begin n_miss++; $display("FAIL rm_state: count %0d data %h busy %b", receiver_count, receiver_data, busy); end
    sq.delete(); clear_log(); sender_empty_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    push_range(8'h80, 4);
    run(8);
    n_vec++; if (got_data.size() !== 2) begin n_miss++; $display("FAIL rm_ngroups: got %0d want 2", got_data.size()); end
    if (got_data.size() == 2) begin
      n_vec++; if (got_data[0] !== 64'h8180 || got_cnt[0] !== 4'd2) begin n_miss++; $display("FAIL rm_group0: got %h/%0d want 8180/2", got_data[0], got_cnt[0]); end
      n_vec++; if (got_data[1] !== 64'h8382 || got_cnt[1] !== 4'd2) begin n_miss++; $display("FAIL rm_group1: got %h/%0d want 8382/2", got_data[1], got_cnt[1]); end
    end
  endtask

  initial begin
    test_reset();
    test_default_width();
    test_width_change();
    test_flush();
    test_back_to_back();
    test_clamp();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
